estacao_reserva_add: RTL



---
 rtl/estacao_reserva_add.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/estacao_reserva_add.sv
// Single-entry ADD/SUB reservation station with CDB snooping and broadcast.
// Optional signed-overflow output enabled by RS_OVERFLOW_EN.
module estacao_reserva_add #(
  parameter logic [2:0]  STATION_ID   = 3'd1,
  parameter int unsigned EXEC_LATENCY = 2,
  parameter logic [2:0]  OPCODE_SUB   = 3'b001,
  parameter logic [15:0] SEM_VALOR    = 16'hFFF0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [2:0]  Opcode,
  input  logic [15:0] Vj,
  input  logic [15:0] Vk,
  input  logic [2:0]  Qj,
  input  logic [2:0]  Qk,
  input  logic        CDB_Valid,
  input  logic [2:0]  CDB_Tag,
  input  logic [15:0] CDB_Data,
  input  logic        CDB_Grant,
  output logic        Ready,
  output logic        Busy,
  output logic        CDB_Req,
  output logic [2:0]  Out_Tag,
  output logic [15:0] Out_Data
`ifdef RS_OVERFLOW_EN
  ,
  output logic        Overflow
`endif
);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    WAIT_OPS = 2'd1,
    EXEC     = 2'd2,
    WRITE    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] vj_q, vj_d;
  logic [15:0] vk_q, vk_d;
  logic [2:0]  qj_q, qj_d;
  logic [2:0]  qk_q, qk_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;

  logic        fwd_j, fwd_k;
  logic        hit_j, hit_k;
  logic        is_sub;
  logic [15:0] result;

`ifdef RS_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic ovf_calc;
`endif

  // Tag matches: dispatch-time forwarding and pending-operand capture
  always_comb begin
    fwd_j = CDB_Valid && (Qj != 3'd0) && (CDB_Tag == Qj);
    fwd_k = CDB_Valid && (Qk != 3'd0) && (CDB_Tag == Qk);
    hit_j = CDB_Valid && (qj_q != 3'd0) && (CDB_Tag == qj_q);
    hit_k = CDB_Valid && (qk_q != 3'd0) && (CDB_Tag == qk_q);
  end

  // ALU: wrap-around add/sub on the latched operands
  always_comb begin
    is_sub = (op_q == OPCODE_SUB);
    result = is_sub ? (vj_q - vk_q) : (vj_q + vk_q);
`ifdef RS_OVERFLOW_EN
    if (is_sub)
      ovf_calc = (vj_q[15] != vk_q[15]) && (result[15] != vj_q[15]);
    else
      ovf_calc = (vj_q[15] == vk_q[15]) && (result[15] != vj_q[15]);
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef RS_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      FREE: begin
        if (Enable) begin
          op_d = Opcode;
          vj_d = fwd_j ? CDB_Data : Vj;
          qj_d = fwd_j ? 3'd0 : Qj;
          vk_d = fwd_k ? CDB_Data : Vk;
          qk_d = fwd_k ? 3'd0 : Qk;
          if ((qj_d == 3'd0) && (qk_d == 3'd0)) begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        if (hit_j) begin
          vj_d = CDB_Data;
          qj_d = 3'd0;
        end
        if (hit_k) begin
          vk_d = CDB_Data;
          qk_d = 3'd0;
        end
        if ((qj_d == 3'd0) && (qk_d == 3'd0)) begin
          state_d = EXEC;
          cnt_d   = CNT_LOAD;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          data_d  = result;
          state_d = WRITE;
`ifdef RS_OVERFLOW_EN
          ovf_d   = ovf_calc;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        if (CDB_Grant) begin
          state_d = FREE;
`ifdef RS_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = FREE;
    endcase
  end

  // State and datapath registers, synchronous reset aborts any op
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FREE;
      op_q    <= 3'd0;
      vj_q    <= SEM_VALOR;
      vk_q    <= SEM_VALOR;
      qj_q    <= 3'd0;
      qk_q    <= 3'd0;
      cnt_q   <= 4'd0;
      data_q  <= SEM_VALOR;
`ifdef RS_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef RS_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status and broadcast outputs decoded from state
  always_comb begin
    Ready    = (state_q == FREE);
    Busy     = ~Ready;
    CDB_Req  = (state_q == WRITE);
    Out_Tag  = CDB_Req ? STATION_ID : 3'd0;
    Out_Data = data_q;
`ifdef RS_OVERFLOW_EN
    Overflow = CDB_Req & ovf_q;
`endif
  end

endmodule
